// File: rtl/mips_run_controller_if.sv
// Run-controller bus: start/retire inputs from the bench or FPGA top,
// core_reset and run status outputs from the controller.
interface mips_run_controller_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             core_reset;
  logic             instr_valid;
  logic [31:0]      instr_word;
  logic [31:0]      pc;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] retired_count;
  logic [31:0]      halt_pc;
  logic             done;
  logic             pass;
  logic             timeout;
  logic [1:0]       state;

  // Controller side
  modport master (
    input  start, instr_valid, instr_word, pc,
    output core_reset, cycle_count, retired_count, halt_pc,
           done, pass, timeout, state
  );

  // Environment side (bench, FPGA top, core wrapper)
  modport slave (
    output start, instr_valid, instr_word, pc,
    input  core_reset, cycle_count, retired_count, halt_pc,
           done, pass, timeout, state
  );
endinterface

// File: rtl/mips_run_controller.sv
// Run/halt sequencer for MIPS core bring-up: holds the core in reset for
// RESET_CYCLES, runs it, and stops on the HALT_WORD instruction or after
// MAX_CYCLES run cycles, reporting done/pass/timeout and the halt PC.
// Optional macro MIPS_RUN_LOOP_DETECT_EN: two consecutive retirements at the
// same PC (branch-to-self) also end the run as a pass.
module mips_run_controller #(
  parameter int          RESET_CYCLES = 4,
  parameter int          MAX_CYCLES   = 10000,
  parameter int          CNT_W        = 32,
  parameter logic [31:0] HALT_WORD    = 32'h0000000C
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_run_controller_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ALL_ONES = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT    = CNT_W'(MAX_CYCLES);
  localparam logic [7:0]       HOLD_LAST    = 8'(RESET_CYCLES - 1);

  state_t           state_q, state_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [31:0]      halt_pc_q, halt_pc_d;
  logic [31:0]      last_pc_q, last_pc_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic             core_reset_q, core_reset_d;
`ifdef MIPS_RUN_LOOP_DETECT_EN
  logic             last_vld_q, last_vld_d;
`endif

  logic [CNT_W-1:0] cycle_inc;
  logic             halt_hit;
  logic             loop_hit;
  logic             timeout_hit;
  logic             end_run;
  logic             restart;

  // Decode the run-ending events for the current RUN cycle
  always_comb begin
    cycle_inc   = cycle_q + 1'b1;
    halt_hit    = bus.instr_valid && (bus.instr_word == HALT_WORD);
    loop_hit    = 1'b0;
`ifdef MIPS_RUN_LOOP_DETECT_EN
    loop_hit    = bus.instr_valid && last_vld_q && (bus.pc == last_pc_q);
`endif
    timeout_hit = (cycle_inc == CNT_LIMIT);
    end_run     = halt_hit || loop_hit || timeout_hit;
    restart     = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start)              state_d = S_HOLD;
      S_HOLD: if (hold_cnt_q == HOLD_LAST) state_d = S_RUN;
      S_RUN:  if (end_run)                state_d = S_DONE;
      S_DONE: if (bus.start)              state_d = S_HOLD;
      default:                            state_d = S_IDLE;
    endcase
  end

  // Counter, flag and halt-PC updates; halt beats loop beats timeout
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    cycle_d    = cycle_q;
    retired_d  = retired_q;
    halt_pc_d  = halt_pc_q;
    last_pc_d  = last_pc_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
`ifdef MIPS_RUN_LOOP_DETECT_EN
    last_vld_d = last_vld_q;
`endif
    if (restart) begin
      hold_cnt_d = '0;
      cycle_d    = '0;
      retired_d  = '0;
      halt_pc_d  = '0;
      last_pc_d  = '0;
      pass_d     = 1'b0;
      timeout_d  = 1'b0;
`ifdef MIPS_RUN_LOOP_DETECT_EN
      last_vld_d = 1'b0;
`endif
    end else if (state_q == S_HOLD) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end else if (state_q == S_RUN) begin
      cycle_d = cycle_inc;
      if (bus.instr_valid) begin
        if (retired_q != CNT_ALL_ONES) retired_d = retired_q + 1'b1;
        last_pc_d = bus.pc;
`ifdef MIPS_RUN_LOOP_DETECT_EN
        last_vld_d = 1'b1;
`endif
      end
      if (halt_hit || loop_hit) begin
        pass_d    = 1'b1;
        halt_pc_d = bus.pc;
      end else if (timeout_hit) begin
        timeout_d = 1'b1;
        halt_pc_d = bus.instr_valid ? bus.pc : last_pc_q;
      end
    end
    // Core runs only while in RUN; registered so it changes on the entry edge
    core_reset_d = (state_d != S_RUN);
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt_q   <= '0;
      cycle_q      <= '0;
      retired_q    <= '0;
      halt_pc_q    <= '0;
      last_pc_q    <= '0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      core_reset_q <= 1'b1;
`ifdef MIPS_RUN_LOOP_DETECT_EN
      last_vld_q   <= 1'b0;
`endif
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      cycle_q      <= cycle_d;
      retired_q    <= retired_d;
      halt_pc_q    <= halt_pc_d;
      last_pc_q    <= last_pc_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      core_reset_q <= core_reset_d;
`ifdef MIPS_RUN_LOOP_DETECT_EN
      last_vld_q   <= last_vld_d;
`endif
    end
  end

  // Output drive
  always_comb begin
    bus.core_reset    = core_reset_q;
    bus.cycle_count   = cycle_q;
    bus.retired_count = retired_q;
    bus.halt_pc       = halt_pc_q;
    bus.done          = (state_q == S_DONE);
    bus.pass          = pass_q;
    bus.timeout       = timeout_q;
    bus.state         = state_q;
  end

endmodule

// File: tb/tb_mips_run_controller.sv
// Bench for mips_run_controller (RESET_CYCLES=4, MAX_CYCLES=20).
// Each scenario pushes the expected end-of-run record before driving it;
// a monitor pops and compares when done rises.
module tb_mips_run_controller;
  localparam logic [31:0] HALT = 32'h0000000C;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_run_controller_if #(.CNT_W(32)) bus ();

  mips_run_controller #(
    .RESET_CYCLES(4),
    .MAX_CYCLES  (20),
    .CNT_W       (32),
    .HALT_WORD   (HALT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic        pass;
    logic        timeout;
    logic [31:0] halt_pc;
    logic [31:0] retired;
    logic [31:0] cycles;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   tests_run    = 0;
  int   tests_failed = 0;
  logic done_seen    = 1'b0;

  // Scoreboard monitor and flag invariants, sampled on the falling edge
  always @(negedge clk) begin
    tests_run++;
    if ((bus.pass && bus.timeout) || (!bus.done && (bus.pass || bus.timeout))) begin
      tests_failed++;
      $display("FAIL invariant: done=%b pass=%b timeout=%b, required pass&timeout=0 and both 0 when done=0",
               bus.done, bus.pass, bus.timeout);
    end
    if (bus.done === 1'b1 && !done_seen) begin
      tests_run++;
      if (sb_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_done: done rose with no expected run queued");
      end else begin
        mon_e = sb_q.pop_front();
        if (bus.pass !== mon_e.pass || bus.timeout !== mon_e.timeout ||
            bus.halt_pc !== mon_e.halt_pc || bus.retired_count !== mon_e.retired ||
            bus.cycle_count !== mon_e.cycles) begin
          tests_failed++;
          $display("FAIL run_result: got pass=%b timeout=%b halt_pc=%h retired=%0d cycles=%0d, required pass=%b timeout=%b halt_pc=%h retired=%0d cycles=%0d",
                   bus.pass, bus.timeout, bus.halt_pc, bus.retired_count, bus.cycle_count,
                   mon_e.pass, mon_e.timeout, mon_e.halt_pc, mon_e.retired, mon_e.cycles);
        end else begin
          $display("[TB] run done: pass=%b timeout=%b halt_pc=%h retired=%0d cycles=%0d",
                   bus.pass, bus.timeout, bus.halt_pc, bus.retired_count, bus.cycle_count);
        end
      end
    end
    done_seen <= (bus.done === 1'b1);
  end

  // Present one cycle of retire inputs, return at the next falling edge
  task automatic step(input logic v, input logic [31:0] w, input logic [31:0] p);
    bus.instr_valid = v;
    bus.instr_word  = w;
    bus.pc          = p;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr_word  = 32'h0;
    bus.pc          = 32'h0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (bus.done !== 1'b1 && n < bound) begin
      step(1'b0, 32'h0, 32'h0);
      n++;
    end
    tests_run++;
    if (bus.done !== 1'b1) begin
      tests_failed++;
      $display("FAIL wait_done: done=%b after %0d cycles, required 1", bus.done, n);
    end
  endtask

  // Pulse start, count HOLD cycles, check clean RUN entry
  task automatic enter_run(input bit poke_start);
    int hold = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    tests_run++;
    if (bus.state !== 2'd1 || bus.done !== 1'b0 || bus.pass !== 1'b0 || bus.timeout !== 1'b0 ||
        bus.cycle_count !== 32'd0 || bus.retired_count !== 32'd0 || bus.halt_pc !== 32'd0) begin
      tests_failed++;
      $display("FAIL hold_entry: state=%0d done=%b pass=%b timeout=%b cyc=%0d ret=%0d halt_pc=%h, required state=1 and all cleared",
               bus.state, bus.done, bus.pass, bus.timeout, bus.cycle_count, bus.retired_count, bus.halt_pc);
    end
    while (bus.state === 2'd1 && hold < 20) begin
      tests_run++;
      if (bus.core_reset !== 1'b1) begin
        tests_failed++;
        $display("FAIL hold_core_reset: core_reset=%b in HOLD, required 1", bus.core_reset);
      end
      if (poke_start && hold == 1) bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      hold++;
    end
    tests_run++;
    if (hold != 4 || bus.state !== 2'd2 || bus.core_reset !== 1'b0 || bus.cycle_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL run_entry: hold_cycles=%0d state=%0d core_reset=%b cyc=%0d, required 4, 2, 0, 0",
               hold, bus.state, bus.core_reset, bus.cycle_count);
    end
    $display("[TB] run started after %0d hold cycles", hold);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.state !== 2'd0 || bus.core_reset !== 1'b1 || bus.done !== 1'b0 ||
        bus.cycle_count !== 32'd0 || bus.retired_count !== 32'd0 || bus.halt_pc !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_state: state=%0d core_reset=%b done=%b cyc=%0d ret=%0d halt_pc=%h, required 0,1,0,0,0,0",
               bus.state, bus.core_reset, bus.done, bus.cycle_count, bus.retired_count, bus.halt_pc);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.state !== 2'd0 || bus.core_reset !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_state: state=%0d core_reset=%b, required 0,1", bus.state, bus.core_reset);
    end
    enter_run(1'b0);
  endtask

  task automatic test_halt();
    sb_q.push_back('{1'b1, 1'b0, 32'h0040001C, 32'd6, 32'd6});
    for (int k = 0; k < 5; k++) step(1'b1, 32'h24080000 + k, 32'h00400000 + 4 * k);
    step(1'b1, HALT, 32'h0040001C);
    tests_run++;
    if (bus.done !== 1'b1 || bus.state !== 2'd3 || bus.core_reset !== 1'b1) begin
      tests_failed++;
      $display("FAIL halt_latency: done=%b state=%0d core_reset=%b, required 1,3,1",
               bus.done, bus.state, bus.core_reset);
    end
    step(1'b1, 32'h24080000, 32'h00400020);
    tests_run++;
    if (bus.cycle_count !== 32'd6 || bus.retired_count !== 32'd6) begin
      tests_failed++;
      $display("FAIL done_hold: cyc=%0d ret=%0d, required 6,6", bus.cycle_count, bus.retired_count);
    end
  endtask

  task automatic test_timeout();
    enter_run(1'b0);
    sb_q.push_back('{1'b0, 1'b1, 32'h00400008, 32'd3, 32'd20});
    for (int k = 0; k < 3; k++) step(1'b1, 32'h00000000, 32'h00400000 + 4 * k);
    wait_done(30);
    enter_run(1'b0);
    sb_q.push_back('{1'b1, 1'b0, 32'h00400050, 32'd1, 32'd20});
    repeat (19) step(1'b0, 32'h0, 32'h0);
    tests_run++;
    if (bus.state !== 2'd2 || bus.cycle_count !== 32'd19) begin
      tests_failed++;
      $display("FAIL pre_timeout: state=%0d cyc=%0d, required 2,19", bus.state, bus.cycle_count);
    end
    step(1'b1, HALT, 32'h00400050);
    tests_run++;
    if (bus.done !== 1'b1) begin
      tests_failed++;
      $display("FAIL halt_on_limit: done=%b, required 1", bus.done);
    end
  endtask

  task automatic test_reset_midrun();
    enter_run(1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 32'h00000000, 32'h00400000 + 4 * k);
    repeat (4) step(1'b0, 32'h0, 32'h0);
    tests_run++;
    if (bus.cycle_count !== 32'd7 || bus.retired_count !== 32'd3) begin
      tests_failed++;
      $display("FAIL midrun_count: cyc=%0d ret=%0d, required 7,3", bus.cycle_count, bus.retired_count);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (bus.state !== 2'd0 || bus.core_reset !== 1'b1 || bus.done !== 1'b0 ||
        bus.cycle_count !== 32'd0 || bus.retired_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL async_abort: state=%0d core_reset=%b done=%b cyc=%0d ret=%0d, required 0,1,0,0,0",
               bus.state, bus.core_reset, bus.done, bus.cycle_count, bus.retired_count);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    enter_run(1'b0);
    sb_q.push_back('{1'b1, 1'b0, 32'h00400100, 32'd1, 32'd2});
    step(1'b0, 32'h0, 32'h0);
    step(1'b1, HALT, 32'h00400100);
    wait_done(5);
  endtask

  task automatic test_back_to_back();
    tests_run++;
    if (bus.done !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_precond: done=%b, required 1", bus.done);
    end
    enter_run(1'b1);
    sb_q.push_back('{1'b1, 1'b0, 32'h00400204, 32'd2, 32'd3});
    step(1'b1, 32'h00000000, 32'h00400200);
    bus.start = 1'b1;
    step(1'b0, 32'h0, 32'h0);
    bus.start = 1'b0;
    tests_run++;
    if (bus.state !== 2'd2 || bus.cycle_count !== 32'd2 || bus.core_reset !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_in_run: state=%0d cyc=%0d core_reset=%b, required 2,2,0",
               bus.state, bus.cycle_count, bus.core_reset);
    end
    step(1'b1, HALT, 32'h00400204);
    wait_done(5);
  endtask

  task automatic test_loop_detect();
    enter_run(1'b0);
`ifdef MIPS_RUN_LOOP_DETECT_EN
    sb_q.push_back('{1'b1, 1'b0, 32'h00400008, 32'd2, 32'd3});
`else
    sb_q.push_back('{1'b0, 1'b1, 32'h00400008, 32'd2, 32'd20});
`endif
    step(1'b1, 32'h1000FFFF, 32'h00400008);
    step(1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h1000FFFF, 32'h00400008);
    wait_done(30);
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr_word  = 32'h0;
    bus.pc          = 32'h0;
    test_reset();
    test_halt();
    test_timeout();
    test_reset_midrun();
    test_back_to_back();
    test_loop_detect();
    repeat (2) @(negedge clk);
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d expected runs left, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
